// File: rtl/register_file.sv
// Architectural register file with per-register rename tags, commit bypass on
// the read ports, and a running count of renamed registers.
module register_file #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 readyIn,
  input  logic                 clear,
  input  logic                 regUpdateValid,
  input  logic [4:0]           regUpdateDest,
  input  logic [31:0]          regValue,
  input  logic [ROB_WIDTH-1:0] regUpdateRobId,
  input  logic                 renameValid,
  input  logic [4:0]           renameDest,
  input  logic [ROB_WIDTH-1:0] renameRobId,
  input  logic [4:0]           rs1,
  output logic [31:0]          rs1Value,
  output logic                 rs1Dirty,
  output logic [ROB_WIDTH-1:0] rs1Dep,
  input  logic [4:0]           rs2,
  output logic [31:0]          rs2Value,
  output logic                 rs2Dirty,
  output logic [ROB_WIDTH-1:0] rs2Dep,
  output logic [5:0]           dirtyCount
);

  localparam int NUM_REGS = 32;

  logic [31:0]          r_value [NUM_REGS];
  logic [ROB_WIDTH-1:0] r_dep   [NUM_REGS];
  logic [NUM_REGS-1:0]  r_dirty;
  logic [5:0]           r_dirty_count;

  logic [NUM_REGS-1:0]  w_commit_sel;
  logic [NUM_REGS-1:0]  w_commit_match;
  logic [NUM_REGS-1:0]  w_rename_sel;
  logic [NUM_REGS-1:0]  w_dirty_next;
  logic [5:0]           w_dirty_count_next;

  // Per-register decode; x0 never selects, so it stays clean and zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_commit_sel[gi]   = 1'b0;
        assign w_commit_match[gi] = 1'b0;
        assign w_rename_sel[gi]   = 1'b0;
        assign w_dirty_next[gi]   = 1'b0;
      end else begin : g_live
        assign w_commit_sel[gi]   = regUpdateValid && (regUpdateDest == 5'(gi));
        assign w_commit_match[gi] = w_commit_sel[gi] && r_dirty[gi] &&
                                    (r_dep[gi] == regUpdateRobId);
        assign w_rename_sel[gi]   = renameValid && !clear && (renameDest == 5'(gi));
        // Rename wins over a matching commit; a flush wins over both.
        assign w_dirty_next[gi]   = clear             ? 1'b0 :
                                    w_rename_sel[gi]   ? 1'b1 :
                                    w_commit_match[gi] ? 1'b0 :
                                                         r_dirty[gi];
      end
    end
  endgenerate

  always_comb begin
    w_dirty_count_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_dirty_count_next = w_dirty_count_next + 6'(w_dirty_next[i]);
    end
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      r_dirty       <= '0;
      r_dirty_count <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_value[i] <= '0;
        r_dep[i]   <= '0;
      end
    end else if (readyIn) begin
      r_dirty       <= w_dirty_next;
      r_dirty_count <= w_dirty_count_next;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_commit_sel[i]) begin
          r_value[i] <= regValue;
        end
        if (w_rename_sel[i]) begin
          r_dep[i] <= renameRobId;
        end
      end
    end
  end

  assign dirtyCount = r_dirty_count;

  logic [1:0][31:0]          w_rd_value;
  logic [1:0]                w_rd_dirty;
  logic [1:0][ROB_WIDTH-1:0] w_rd_dep;

  // Read ports see the pre-rename mapping, with a committing value bypassed
  // straight through when it resolves the register's current rename.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [4:0] w_idx;
      logic       w_bypass;
      assign w_idx    = (gi == 0) ? rs1 : rs2;
      assign w_bypass = regUpdateValid && (w_idx != 5'd0) && (w_idx == regUpdateDest) &&
                        r_dirty[w_idx] && (r_dep[w_idx] == regUpdateRobId);
      assign w_rd_value[gi] = (w_idx == 5'd0) ? 32'd0 :
                              w_bypass        ? regValue : r_value[w_idx];
      assign w_rd_dirty[gi] = (w_idx != 5'd0) && !w_bypass && r_dirty[w_idx];
      assign w_rd_dep[gi]   = (w_idx == 5'd0) ? '0 : r_dep[w_idx];
    end
  endgenerate

  assign rs1Value = w_rd_value[0];
  assign rs1Dirty = w_rd_dirty[0];
  assign rs1Dep   = w_rd_dep[0];
  assign rs2Value = w_rd_value[1];
  assign rs2Dirty = w_rd_dirty[1];
  assign rs2Dep   = w_rd_dep[1];

endmodule
